// File: rtl/adder_if_pkg.sv
// Shared definitions for the adder operand/register-access interface:
// command encodings, register map and the initiator state encoding.
package adder_if_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_OFFSET   = 3'd1;
  localparam logic [2:0] REG_GP       = 3'd2;
  localparam logic [2:0] REG_ADDR_MAX = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_SUM = 3'd2,
    ST_WAIT_RD  = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  function automatic logic addr_bad(input logic [2:0] addr);
    return (addr > REG_ADDR_MAX);
  endfunction

endpackage

// File: rtl/adder_reg_initiator.sv
// Single-outstanding initiator: takes add/write/read commands, drives the
// adder's operand and Des_* inputs for one cycle, and returns the result.
module adder_reg_initiator
  import adder_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_cin,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_err,
  output logic       Data_val,
  output logic [7:0] Value_a,
  output logic [7:0] Value_b,
  output logic       c_in,
  output logic [2:0] Des_address,
  output logic [7:0] Des_value,
  output logic       Des_req_valid,
  output logic       Des_wr_rd,
  input  logic [7:0] Sum_result,
  input  logic       Sum_carry,
  input  logic       Data_ready,
  input  logic [7:0] Des_rd_value
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_r, state_s;
  op_e           op_r;
  logic [2:0]    addr_r;
  logic [7:0]    data_r;
  logic [CW-1:0] cnt_r;

  logic       accept_s, sum_hit_s, timeout_s;
  logic       cmd_ready_s, rsp_valid_s, rsp_carry_s, rsp_err_s;
  logic [7:0] rsp_data_s;
  logic       data_val_s, c_in_s, des_req_valid_s, des_wr_rd_s;
  logic [7:0] value_a_s, value_b_s, des_value_s;
  logic [2:0] des_address_s;

  assign accept_s  = cmd_ready && cmd_valid;
  // Counts 0,1 cover stale Data_ready from earlier transactions; the cycle
  // with count TIMEOUT_CYCLES-1 is the last of TIMEOUT_CYCLES wait cycles.
  assign sum_hit_s = Data_ready && (cnt_r >= CW'(2));
  assign timeout_s = (cnt_r == CW'(TIMEOUT_CYCLES - 1));

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = (op_e'(cmd_op) == OP_RSVD) ? ST_RESP : ST_ISSUE;
        else          state_s = ST_IDLE;
      end
      ST_ISSUE: begin
        case (op_r)
          OP_ADD:  state_s = ST_WAIT_SUM;
          OP_RD:   state_s = ST_WAIT_RD;
          default: state_s = ST_RESP;
        endcase
      end
      ST_WAIT_RD:  state_s = ST_RESP;
      ST_WAIT_SUM: begin
        if (sum_hit_s || timeout_s) state_s = ST_RESP;
        else                        state_s = ST_WAIT_SUM;
      end
      ST_RESP: begin
        if (rsp_ready) state_s = ST_IDLE;
        else           state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // command capture and wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r   <= OP_ADD;
      addr_r <= 3'd0;
      data_r <= 8'h00;
      cnt_r  <= '0;
    end else begin
      if (accept_s) begin
        op_r   <= op_e'(cmd_op);
        addr_r <= cmd_addr;
        data_r <= cmd_data;
      end
      cnt_r <= (state_r == ST_WAIT_SUM) ? cnt_r + CW'(1) : '0;
    end
  end

  // next values of every registered output
  always_comb begin
    cmd_ready_s     = (state_s == ST_IDLE);
    rsp_valid_s     = (state_s == ST_RESP);
    rsp_data_s      = rsp_data;
    rsp_carry_s     = rsp_carry;
    rsp_err_s       = rsp_err;
    data_val_s      = 1'b0;
    value_a_s       = 8'h00;
    value_b_s       = 8'h00;
    c_in_s          = 1'b0;
    des_address_s   = 3'd0;
    des_value_s     = 8'h00;
    des_req_valid_s = 1'b0;
    des_wr_rd_s     = 1'b0;
    // ISSUE is only entered from an accept, so the cmd_* inputs are current
    if (state_s == ST_ISSUE) begin
      data_val_s = 1'b1;
      case (op_e'(cmd_op))
        OP_ADD: begin
          value_a_s = cmd_a;
          value_b_s = cmd_b;
          c_in_s    = cmd_cin;
        end
        OP_WR: begin
          des_req_valid_s = 1'b1;
          des_wr_rd_s     = 1'b1;
          des_address_s   = cmd_addr;
          des_value_s     = cmd_data;
        end
        OP_RD: begin
          des_req_valid_s = 1'b1;
          des_address_s   = cmd_addr;
        end
        default: data_val_s = 1'b0;
      endcase
    end else if (state_r == ST_ISSUE) begin
      c_in_s = c_in;
    end else begin
      c_in_s = 1'b0;
    end
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (op_e'(cmd_op) == OP_RSVD)) begin
          rsp_data_s  = 8'h00;
          rsp_carry_s = 1'b0;
          rsp_err_s   = 1'b1;
        end else begin
          rsp_data_s = rsp_data;
        end
      end
      ST_ISSUE: begin
        if (op_r == OP_WR) begin
          rsp_data_s  = data_r;
          rsp_carry_s = 1'b0;
          rsp_err_s   = addr_bad(addr_r);
        end else begin
          rsp_data_s = rsp_data;
        end
      end
      ST_WAIT_RD: begin
        rsp_data_s  = Des_rd_value;
        rsp_carry_s = 1'b0;
        rsp_err_s   = addr_bad(addr_r);
      end
      ST_WAIT_SUM: begin
        if (sum_hit_s) begin
          rsp_data_s  = Sum_result;
          rsp_carry_s = Sum_carry;
          rsp_err_s   = 1'b0;
        end else if (timeout_s) begin
          rsp_data_s  = 8'h00;
          rsp_carry_s = 1'b0;
          rsp_err_s   = 1'b1;
        end else begin
          rsp_data_s = rsp_data;
        end
      end
      default: rsp_data_s = rsp_data;
    endcase
  end

  // output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= 8'h00;
      rsp_carry     <= 1'b0;
      rsp_err       <= 1'b0;
      Data_val      <= 1'b0;
      Value_a       <= 8'h00;
      Value_b       <= 8'h00;
      c_in          <= 1'b0;
      Des_address   <= 3'd0;
      Des_value     <= 8'h00;
      Des_req_valid <= 1'b0;
      Des_wr_rd     <= 1'b0;
    end else begin
      cmd_ready     <= cmd_ready_s;
      rsp_valid     <= rsp_valid_s;
      rsp_data      <= rsp_data_s;
      rsp_carry     <= rsp_carry_s;
      rsp_err       <= rsp_err_s;
      Data_val      <= data_val_s;
      Value_a       <= value_a_s;
      Value_b       <= value_b_s;
      c_in          <= c_in_s;
      Des_address   <= des_address_s;
      Des_value     <= des_value_s;
      Des_req_valid <= des_req_valid_s;
      Des_wr_rd     <= des_wr_rd_s;
    end
  end

endmodule

// File: tb/tb_adder_reg_initiator.sv
// Self-checking bench for adder_reg_initiator: adder stub with a scripted
// Data_ready pattern, transaction-level reference model, random + directed tests.
module tb_adder_reg_initiator;
  import adder_if_pkg::*;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_addr = 3'd0;
  logic [7:0] cmd_data = 8'h00, cmd_a = 8'h00, cmd_b = 8'h00;
  logic       cmd_cin = 1'b0;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_carry, rsp_err;
  logic       Data_val, c_in, Des_req_valid, Des_wr_rd;
  logic [7:0] Value_a, Value_b, Des_value;
  logic [2:0] Des_address;
  logic [7:0] Sum_result, Des_rd_value;
  logic       Sum_carry, Data_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_reg_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_cin(cmd_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .Data_val(Data_val), .Value_a(Value_a), .Value_b(Value_b), .c_in(c_in),
    .Des_address(Des_address), .Des_value(Des_value),
    .Des_req_valid(Des_req_valid), .Des_wr_rd(Des_wr_rd),
    .Sum_result(Sum_result), .Sum_carry(Sum_carry), .Data_ready(Data_ready),
    .Des_rd_value(Des_rd_value)
  );

  // Adder stub: mask_cfg bit i raises Data_ready i cycles after the add's Data_val cycle
  logic [31:0] mask_cfg = 32'd0;
  logic [31:0] sr;
  logic [8:0]  sum_q;
  logic [7:0]  rd_q;
  logic [7:0]  stub_regs [0:2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sr    <= 32'd0;
      sum_q <= 9'd0;
      rd_q  <= 8'h00;
      for (int i = 0; i < 3; i++) stub_regs[i] <= 8'h00;
    end else begin
      if (Data_val && !Des_req_valid) begin
        sr    <= mask_cfg >> 1;
        sum_q <= {1'b0, Value_a} + {1'b0, Value_b} + {8'd0, c_in};
      end else begin
        sr <= sr >> 1;
      end
      if (Data_val && Des_req_valid && Des_wr_rd && Des_address <= 3'd2)
        stub_regs[Des_address[1:0]] <= Des_value;
      if (Data_val && Des_req_valid && !Des_wr_rd)
        rd_q <= (Des_address <= 3'd2) ? stub_regs[Des_address[1:0]] : 8'h00;
    end
  end

  assign Data_ready   = sr[0];
  assign Sum_result   = sr[0] ? sum_q[7:0] : 8'hA5;
  assign Sum_carry    = sr[0] ? sum_q[8] : 1'b1;
  assign Des_rd_value = rd_q;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: register contents plus response/latency per command
  logic [7:0] mdl_regs [0:2];

  task automatic model(input logic [1:0] op, input logic [2:0] addr, input logic [7:0] data,
                       input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [31:0] mask, output int lat, output logic [7:0] d,
                       output logic c, output logic e);
    logic [8:0] s;
    case (op)
      2'b00: begin
        lat = TO + 2; d = 8'h00; c = 1'b0; e = 1'b1;
        for (int i = 3; i <= TO; i++) begin
          if (mask[i]) begin
            s = 9'(a) + 9'(b) + 9'(cin);
            lat = i + 2; d = s[7:0]; c = s[8]; e = 1'b0;
            break;
          end
        end
      end
      2'b01: begin
        lat = 2; d = data; c = 1'b0; e = (addr > 3'd2);
        if (addr <= 3'd2) mdl_regs[addr[1:0]] = data;
      end
      2'b10: begin
        lat = 3; c = 1'b0; e = (addr > 3'd2);
        d = (addr <= 3'd2) ? mdl_regs[addr[1:0]] : 8'h00;
      end
      default: begin
        lat = 1; d = 8'h00; c = 1'b0; e = 1'b1;
      end
    endcase
  endtask

  int         last_lat;
  logic [7:0] last_data;
  logic       last_carry, last_err;

  task automatic do_cmd(input logic [1:0] op, input logic [2:0] addr, input logic [7:0] data,
                        input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [31:0] mask, input int hold);
    int exp_lat, k, w, held;
    logic [7:0] ed;
    logic ec, ee, done, first, is_reg;
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_a = a; cmd_b = b; cmd_cin = cin;
    mask_cfg = mask; cmd_valid = 1'b1; rsp_ready = 1'b0;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", 32'(w < 20), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    model(op, addr, data, a, b, cin, mask, exp_lat, ed, ec, ee);
    is_reg = (op == 2'b01) || (op == 2'b10);
    k = 0; held = 0; done = 1'b0; first = 1'b1; last_lat = -1;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      chk("data_val",  32'(Data_val), 32'(k == 1 && op != 2'b11));
      chk("value_a",   32'(Value_a), (k == 1 && op == 2'b00) ? 32'(a) : 32'd0);
      chk("value_b",   32'(Value_b), (k == 1 && op == 2'b00) ? 32'(b) : 32'd0);
      chk("c_in",      32'(c_in), 32'(op == 2'b00 && cin && (k == 1 || k == 2)));
      chk("des_req",   32'(Des_req_valid), 32'(k == 1 && is_reg));
      chk("des_wr_rd", 32'(Des_wr_rd), 32'(k == 1 && op == 2'b01));
      chk("des_addr",  32'(Des_address), (k == 1 && is_reg) ? 32'(addr) : 32'd0);
      chk("des_value", 32'(Des_value), (k == 1 && op == 2'b01) ? 32'(data) : 32'd0);
      chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(k >= exp_lat));
      if (rsp_valid) begin
        if (first) begin
          last_lat = k;
          first = 1'b0;
        end
        last_data = rsp_data; last_carry = rsp_carry; last_err = rsp_err;
        chk("rsp_data",  32'(rsp_data), 32'(ed));
        chk("rsp_carry", 32'(rsp_carry), 32'(ec));
        chk("rsp_err",   32'(rsp_err), 32'(ee));
        if (held >= hold) begin
          rsp_ready = 1'b1;
          done = 1'b1;
        end else begin
          held++;
        end
      end
    end
    chk("rsp_seen", 32'(done), 32'd1);
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] m;
    int r;
    for (int i = 0; i < 3; i++) mdl_regs[i] = 8'h00;

    // power-on reset
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(|{cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err, Data_val,
                            Value_a, Value_b, c_in, Des_address, Des_value, Des_req_valid,
                            Des_wr_rd}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_release_ready", 32'(cmd_ready), 32'd1);

    // adds
    do_cmd(2'b00, 3'd0, 8'h00, 8'h7F, 8'h01, 1'b0, 32'h8, 0);
    chk("add7f_data", 32'(last_data), 32'h80);
    chk("add7f_carry", 32'(last_carry), 32'd0);
    chk("add7f_lat", 32'(last_lat), 32'd5);
    do_cmd(2'b00, 3'd0, 8'h00, 8'hFF, 8'h01, 1'b1, 32'h8, 0);
    chk("addff_data", 32'(last_data), 32'h01);
    chk("addff_carry", 32'(last_carry), 32'd1);

    // register access
    do_cmd(2'b01, 3'd1, 8'h05, 8'h00, 8'h00, 1'b0, 32'd0, 0);
    chk("wr1_data", 32'(last_data), 32'h05);
    chk("wr1_lat", 32'(last_lat), 32'd2);
    do_cmd(2'b10, 3'd1, 8'h00, 8'h00, 8'h00, 1'b0, 32'd0, 0);
    chk("rd1_data", 32'(last_data), 32'h05);
    chk("rd1_err", 32'(last_err), 32'd0);
    chk("rd1_lat", 32'(last_lat), 32'd3);
    do_cmd(2'b10, 3'd5, 8'h00, 8'h00, 8'h00, 1'b0, 32'd0, 0);
    chk("rd5_err", 32'(last_err), 32'd1);

    // timeouts, including an early Data_ready pulse that must be ignored
    do_cmd(2'b00, 3'd0, 8'h00, 8'h12, 8'h34, 1'b0, 32'd0, 0);
    chk("to_err", 32'(last_err), 32'd1);
    chk("to_data", 32'(last_data), 32'd0);
    chk("to_lat", 32'(last_lat), 32'(TO + 2));
    do_cmd(2'b00, 3'd0, 8'h00, 8'h12, 8'h34, 1'b0, 32'h4, 0);
    chk("early_pulse_err", 32'(last_err), 32'd1);

    // back-pressure and reserved op
    do_cmd(2'b11, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 32'd0, 4);
    chk("rsvd_err", 32'(last_err), 32'd1);
    chk("rsvd_lat", 32'(last_lat), 32'd1);
    do_cmd(2'b00, 3'd0, 8'h00, 8'h40, 8'h41, 1'b1, 32'h10, 4);
    chk("bp_add_data", 32'(last_data), 32'h82);

    // reset during WAIT_SUM
    @(negedge clk);
    cmd_op = 2'b00; cmd_a = 8'h11; cmd_b = 8'h22; cmd_cin = 1'b1;
    mask_cfg = 32'd0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("midrst_outs", 32'(|{cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err, Data_val,
                                 Value_a, Value_b, c_in, Des_address, Des_value,
                                 Des_req_valid, Des_wr_rd}), 32'd0);
    @(negedge clk);
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) mdl_regs[i] = 8'h00;
    @(negedge clk);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_valid2", 32'(rsp_valid), 32'd0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      r = int'($urandom_range(0, 3));
      m = 32'd0;
      if (r != 0) m = m | (32'd1 << $urandom_range(3, TO + 2));
      if (r == 2) m = m | (32'd1 << $urandom_range(1, 2));
      do_cmd(op, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom), m, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
